uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. It captures each completed byte from the receiver's level-type "byte ready" flag into a circular FIFO and presents a registered read port to the pipeline's IO load path. It also tracks overflow and the number of complete lines (terminator bytes) currently buffered, so software can poll for whole commands.

## Interface
Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes (16).
- TERM, 8'h0A, line-terminator byte value counted by o_lines.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_rx_data  in  8  received byte from the UART receiver, stable while i_rx_ready is high.
- i_rx_ready  in  1  receiver byte-ready flag (level, held high until next frame starts).
- i_rd_en  in  1  read request from the pipeline.
- i_clr_ovf  in  1  clears o_overflow and o_drop_count.
- o_rd_data  out  8  read data, registered.
- o_rd_valid  out  1  one-cycle pulse: o_rd_data holds a newly popped byte.
- o_empty  out  1  FIFO holds 0 bytes.
- o_full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
- o_count  out  DEPTH_LOG2+1  bytes stored.
- o_lines  out  DEPTH_LOG2+1  TERM bytes stored.
- o_overflow  out  1  sticky: a byte was dropped.
- o_drop_count  out  8  dropped bytes, saturating at 255.

## Operation
- Write strobe wr = i_rx_ready & ~rdy_q; rdy_q is i_rx_ready registered, reset 0. One write per rising edge of i_rx_ready; a held-high flag never writes twice.
- Read strobe rd = i_rd_en & ~o_empty. i_rd_en while empty is ignored: no pop, no o_rd_valid, o_rd_data unchanged.
- Storage: array of 2**DEPTH_LOG2 x 8, write pointer wp and read pointer rp, each DEPTH_LOG2 bits, wrap modulo depth naturally. Count held separately (DEPTH_LOG2+1 bits); o_empty = (count==0), o_full = (count==depth).
- Accepted write (wr & (~o_full | rd)): mem[wp] <= i_rx_data, wp++.
- Pop: o_rd_data <= mem[rp], rp++, o_rd_valid <= 1.
- Count: +1 on accepted write only, -1 on pop only, unchanged on both.
- Full and wr and rd same cycle: both occur, count stays depth, no drop. Empty and wr and rd same cycle: rd ignored, write accepted, count 0->1.
- Drop: wr & o_full & ~rd -> byte discarded, o_overflow <= 1, o_drop_count increments unless 255.
- i_clr_ovf: o_overflow <= 0, o_drop_count <= 0; if a drop happens the same cycle, clear wins for o_overflow, and o_drop_count <= 1 (drop counted after clear).
- Lines: +1 when accepted write byte == TERM, -1 when popped byte == TERM, unchanged if both. o_lines never exceeds o_count.
- Reset (i_rst==0 at clock edge): wp, rp, count, o_lines, o_overflow, o_drop_count, o_rd_data, o_rd_valid, rdy_q all 0; o_empty=1, o_full=0. Memory contents not reset. Reset mid-stream discards buffered bytes; an i_rx_ready already high at reset release does not write (rdy_q resets to 0 but write requires rdy_q from previous non-reset cycle — implement rdy_q <= i_rx_ready during reset so no spurious write).

## Timing
- Write: i_rx_ready rises in cycle N -> byte stored, o_count/o_empty/o_full/o_lines updated at edge end of N (visible N+1).
- Read: i_rd_en in cycle N with ~o_empty -> o_rd_data and o_rd_valid=1 in N+1; o_rd_valid drops in N+2 unless another pop.
- Back-to-back reads every cycle sustain one byte/cycle.
- Minimum write latency-to-read: byte written at N readable by i_rd_en at N+1, data at N+2.
- All outputs registered; no combinational path input->output.

## Test plan
- Reset then write 'h','i',8'h0A via three rising edges of i_rx_ready (flag held high 20 cycles each) -> o_count=3, o_lines=1, exactly 3 writes.
- Three i_rd_en pulses -> o_rd_data 8'h68, 8'h69, 8'h0A each with o_rd_valid one cycle later; o_empty=1, o_lines=0.
- Write 18 bytes 0x00..0x11 without reads -> o_full=1, o_count=16, o_overflow=1, o_drop_count=2; reads return 0x00..0x0F in order (wrap verified).
- Full FIFO, write and i_rd_en same cycle -> count stays 16, no drop; empty FIFO, same -> count 1, o_rd_valid stays 0.
- i_rd_en on empty -> no o_rd_valid, o_rd_data unchanged; i_clr_ovf -> o_overflow=0, o_drop_count=0.
- Reset asserted with 5 bytes stored and i_rx_ready high -> after release o_count=0, o_empty=1, no write until next rising edge of i_rx_ready.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo: UART receive byte FIFO with overflow and line tracking. r1.0 |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  TERM       = 8'h0A
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_ready,
  input  logic                  i_rd_en,
  input  logic                  i_clr_ovf,
  output logic [7:0]            o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic [DEPTH_LOG2:0]   o_lines,
  output logic                  o_overflow,
  output logic [7:0]            o_drop_count
);

  localparam logic [DEPTH_LOG2:0] c_depth = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [0:(1<<DEPTH_LOG2)-1];
  logic                  rdy_q;
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d, lines_q, lines_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_q, drop_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic       w_empty, w_full, w_wr, w_rd, w_wr_acc, w_drop, w_wr_term, w_rd_term;
  logic [7:0] w_head;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == c_depth);
  assign w_wr      = i_rx_ready & ~rdy_q;
  assign w_rd      = i_rd_en & ~w_empty;
  // A full FIFO still accepts when the same cycle frees a slot.
  assign w_wr_acc  = w_wr & (~w_full | w_rd);
  assign w_drop    = w_wr & w_full & ~w_rd;
  assign w_head    = mem_q[rp_q];
  assign w_wr_term = w_wr_acc & (i_rx_data == TERM);
  assign w_rd_term = w_rd & (w_head == TERM);

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    lines_d    = lines_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = w_rd;

    if (w_wr_acc) wp_d = wp_q + 1'b1;
    if (w_rd) begin
      rp_d      = rp_q + 1'b1;
      rd_data_d = w_head;
    end

    case ({w_wr_acc, w_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case ({w_wr_term, w_rd_term})
      2'b10:   lines_d = lines_q + 1'b1;
      2'b01:   lines_d = lines_q - 1'b1;
      default: lines_d = lines_q;
    endcase

    // Clear takes priority for the flag; a simultaneous drop is counted afresh.
    if (i_clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = {7'b0, w_drop};
    end else if (w_drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    rdy_q <= i_rx_ready;
    if (!i_rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      lines_q    <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      lines_q    <= lines_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && w_wr_acc) mem_q[wp_q] <= i_rx_data;
  end

  assign o_rd_data    = rd_data_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_empty      = w_empty;
  assign o_full       = w_full;
  assign o_count      = count_q;
  assign o_lines      = lines_q;
  assign o_overflow   = ovf_q;
  assign o_drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_fifo: directed plus random checks against a queue model. r1.0  |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [7:0] i_rx_data = 8'd0;
  logic       i_rx_ready = 1'b0;
  logic       i_rd_en = 1'b0;
  logic       i_clr_ovf = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_valid, o_empty, o_full, o_overflow;
  logic [4:0] o_count, o_lines;
  logic [7:0] o_drop_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  uart_rx_fifo dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_ready(i_rx_ready),
    .i_rd_en(i_rd_en), .i_clr_ovf(i_clr_ovf), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
    .o_lines(o_lines), .o_overflow(o_overflow), .o_drop_count(o_drop_count)
  );

  // Reference: the FIFO is a queue of bytes; line count is recomputed by scanning it.
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  int         m_drops = 0;
  logic [7:0] m_rdata = 8'd0;
  logic       m_rvalid = 1'b0;
  logic       m_prev = 1'b0;

  task automatic model_step();
    logic wr, pop, drop;
    logic [7:0] b;
    if (!i_rst) begin
      m_q.delete();
      m_ovf = 1'b0; m_drops = 0; m_rdata = 8'd0; m_rvalid = 1'b0;
      m_prev = i_rx_ready;
    end else begin
      wr = i_rx_ready && !m_prev;
      m_prev = i_rx_ready;
      pop = i_rd_en && (m_q.size() > 0);
      drop = 1'b0;
      if (pop) begin
        b = m_q.pop_front();
        m_rdata = b;
      end
      if (wr) begin
        if (m_q.size() < 16) m_q.push_back(i_rx_data);
        else drop = 1'b1;
      end
      m_rvalid = pop;
      if (i_clr_ovf) begin
        m_ovf = 1'b0;
        m_drops = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  function automatic int m_lines();
    int n = 0;
    foreach (m_q[i]) if (m_q[i] == 8'h0A) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",    32'(o_count),      32'(m_q.size()));
    chk("lines",    32'(o_lines),      32'(m_lines()));
    chk("empty",    32'(o_empty),      32'(m_q.size() == 0));
    chk("full",     32'(o_full),       32'(m_q.size() == 16));
    chk("overflow", 32'(o_overflow),   32'(m_ovf));
    chk("drops",    32'(o_drop_count), 32'(m_drops));
    chk("rd_valid", 32'(o_rd_valid),   32'(m_rvalid));
    chk("rd_data",  32'(o_rd_data),    32'(m_rdata));
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    i_rx_data = b;
    i_rx_ready = 1'b1;
    repeat (hold) tick();
    i_rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    // Bring-up reset; outputs are unknown until the first reset edge.
    repeat (2) begin model_step(); @(posedge i_clk); #1; end
    tick();
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    i_rst = 1'b1;
    tick();

    send_byte(8'h68, 20);
    send_byte(8'h69, 20);
    send_byte(8'h0A, 20);
    chk("hi_count", 32'(o_count), 32'd3);
    chk("hi_lines", 32'(o_lines), 32'd1);

    for (int i = 0; i < 3; i++) begin
      i_rd_en = 1'b1; tick();
      i_rd_en = 1'b0;
      chk("hi_valid", 32'(o_rd_valid), 32'd1);
      chk("hi_data",  32'(o_rd_data), (i == 0) ? 32'h68 : (i == 1) ? 32'h69 : 32'h0A);
      tick();
    end
    chk("hi_empty", 32'(o_empty), 32'd1);
    chk("hi_lines0", 32'(o_lines), 32'd0);

    for (int i = 0; i < 18; i++) send_byte(8'(i), 2);
    chk("ovf_full", 32'(o_full), 32'd1);
    chk("ovf_count", 32'(o_count), 32'd16);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    chk("ovf_drops", 32'(o_drop_count), 32'd2);

    i_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("wrap_data", 32'(o_rd_data), 32'(i));
    end
    i_rd_en = 1'b0;
    tick();
    chk("wrap_empty", 32'(o_empty), 32'd1);

    // Empty FIFO with simultaneous write edge and read request.
    i_rx_data = 8'hA5; i_rx_ready = 1'b1; i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    chk("ew_count", 32'(o_count), 32'd1);
    chk("ew_valid", 32'(o_rd_valid), 32'd0);
    i_rx_ready = 1'b0; tick();

    for (int i = 0; i < 15; i++) send_byte(8'h20 + 8'(i), 1);
    chk("fw_full", 32'(o_full), 32'd1);
    i_rx_data = 8'h0A; i_rx_ready = 1'b1; i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    chk("fw_count", 32'(o_count), 32'd16);
    chk("fw_drops", 32'(o_drop_count), 32'd2);
    chk("fw_data", 32'(o_rd_data), 32'hA5);
    i_rx_ready = 1'b0; tick();

    i_rd_en = 1'b1; repeat (18) tick();
    chk("rde_valid", 32'(o_rd_valid), 32'd0);
    chk("rde_data", 32'(o_rd_data), 32'h0A);
    i_rd_en = 1'b0;
    i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
    chk("clr_ovf", 32'(o_overflow), 32'd0);
    chk("clr_drops", 32'(o_drop_count), 32'd0);

    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), 3);
    i_rx_data = 8'h77; i_rx_ready = 1'b1; i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    repeat (4) tick();
    chk("rr_count", 32'(o_count), 32'd0);
    chk("rr_empty", 32'(o_empty), 32'd1);
    i_rx_ready = 1'b0; tick();
    i_rx_ready = 1'b1; tick();
    chk("rr_write", 32'(o_count), 32'd1);
    i_rx_ready = 1'b0; tick();

    // Random traffic including saturation-prone bursts, clears and resets.
    for (int c = 0; c < 4000; c++) begin
      if (i_rx_ready) begin
        if ($urandom_range(0, 2) == 0) i_rx_ready = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        i_rx_data = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
        i_rx_ready = 1'b1;
      end
      i_rd_en   = (c % 1000 < 500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      i_clr_ovf = ($urandom_range(0, 60) == 0);
      i_rst     = ($urandom_range(0, 400) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
